// File: rtl/phy_mdio_ctrl.sv
// phy_mdio_ctrl: Clause-22 MDIO management master.
// Generates MDC from clk_50 (MDC_DIV cycles per half-period), serialises one
// read or write frame per accepted command and returns a one-cycle response.
// Build option MDIO_PRE_SUPPRESS_EN: only the first frame after reset carries
// the 32-bit preamble; later frames start directly with the header.
module phy_mdio_ctrl #(
    parameter int MDC_DIV = 10
) (
    input  logic        clk_50,
    input  logic        reset_n,
    input  logic        phy_ready,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_phyad,
    input  logic [4:0]  cmd_regad,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        phy_mdc,
    inout  wire         phy_mdio
);

    localparam int              HC_W   = $clog2(MDC_DIV);
    localparam logic [HC_W-1:0] HC_MAX = HC_W'(MDC_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_PRE, ST_HDR, ST_TA, ST_DATA, ST_END, ST_RSP
    } state_t;

    state_t          state, state_nx;
    logic [5:0]      bit_cnt, bit_cnt_nx;
    logic [HC_W-1:0] half_cnt;
    logic            mdc_r;
    logic            mdio_o, mdio_oe, mdio_o_nx, mdio_oe_nx;
    logic            wr_l;
    logic [4:0]      phyad_l, regad_l;
    logic [15:0]     wdata_l;
    logic            wr_src;
    logic [13:0]     hdr_src;
    logic [15:0]     wdata_src;
    logic [15:0]     rx_sr;
    logic            ta_err;
    logic            accept, bit_end, sample_pt;
`ifdef MDIO_PRE_SUPPRESS_EN
    logic            pre_done;
`endif

    assign accept    = cmd_valid && cmd_ready;
    // Last cycle of the MDC high phase closes a bit period.
    assign bit_end   = mdc_r && (half_cnt == HC_MAX);
    // First cycle with MDC high: the PHY's bit has been stable since MDC fell.
    assign sample_pt = mdc_r && (half_cnt == '0);

    // On the accept cycle the first bit is chosen from the live command fields,
    // since the latched copy only updates on that same edge.
    assign wr_src    = accept ? cmd_write : wr_l;
    assign hdr_src   = accept ? {2'b01, (cmd_write ? 2'b01 : 2'b10), cmd_phyad, cmd_regad}
                              : {2'b01, (wr_l ? 2'b01 : 2'b10), phyad_l, regad_l};
    assign wdata_src = accept ? cmd_wdata : wdata_l;

    assign phy_mdc   = mdc_r;
    assign phy_mdio  = mdio_oe ? mdio_o : 1'bz;
    assign rsp_valid = (state == ST_RSP);

    // Next-state and bit counter: each frame field counts down to 0, then hands over.
    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        case (state)
            ST_IDLE: begin
                if (accept) begin
`ifdef MDIO_PRE_SUPPRESS_EN
                    if (pre_done) begin
                        state_nx   = ST_HDR;
                        bit_cnt_nx = 6'd13;
                    end else begin
                        state_nx   = ST_PRE;
                        bit_cnt_nx = 6'd31;
                    end
`else
                    state_nx   = ST_PRE;
                    bit_cnt_nx = 6'd31;
`endif
                end
            end
            ST_RSP: state_nx = ST_IDLE;
            default: begin
                if (bit_end) begin
                    if (bit_cnt != 6'd0) begin
                        bit_cnt_nx = bit_cnt - 6'd1;
                    end else begin
                        case (state)
                            ST_PRE:  begin state_nx = ST_HDR;  bit_cnt_nx = 6'd13; end
                            ST_HDR:  begin state_nx = ST_TA;   bit_cnt_nx = 6'd1;  end
                            ST_TA:   begin state_nx = ST_DATA; bit_cnt_nx = 6'd15; end
                            ST_DATA: begin state_nx = ST_END;  bit_cnt_nx = 6'd0;  end
                            default: begin state_nx = ST_RSP;  bit_cnt_nx = 6'd0;  end
                        endcase
                    end
                end
            end
        endcase
    end

    // MDIO drive for the bit that starts next; reads release from TA onward.
    always_comb begin
        mdio_oe_nx = 1'b0;
        mdio_o_nx  = 1'b1;
        case (state_nx)
            ST_PRE: mdio_oe_nx = 1'b1;
            ST_HDR: begin
                mdio_oe_nx = 1'b1;
                mdio_o_nx  = hdr_src[bit_cnt_nx[3:0]];
            end
            ST_TA: begin
                if (wr_src) begin
                    mdio_oe_nx = 1'b1;
                    mdio_o_nx  = bit_cnt_nx[0];
                end
            end
            ST_DATA: begin
                if (wr_src) begin
                    mdio_oe_nx = 1'b1;
                    mdio_o_nx  = wdata_src[bit_cnt_nx[3:0]];
                end
            end
            default: ;
        endcase
    end

    // Control registers: state, counters, MDC, MDIO driver and cmd_ready.
    always_ff @(posedge clk_50) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            bit_cnt   <= 6'd0;
            half_cnt  <= '0;
            mdc_r     <= 1'b0;
            mdio_oe   <= 1'b0;
            mdio_o    <= 1'b1;
            cmd_ready <= 1'b0;
        end else begin
            state     <= state_nx;
            bit_cnt   <= bit_cnt_nx;
            mdio_oe   <= mdio_oe_nx;
            mdio_o    <= mdio_o_nx;
            cmd_ready <= (state_nx == ST_IDLE) && phy_ready;
            if (state == ST_IDLE || state_nx == ST_RSP || state_nx == ST_IDLE) begin
                half_cnt <= '0;
                mdc_r    <= 1'b0;
            end else if (half_cnt == HC_MAX) begin
                half_cnt <= '0;
                mdc_r    <= ~mdc_r;
            end else begin
                half_cnt <= half_cnt + 1'b1;
            end
        end
    end

`ifdef MDIO_PRE_SUPPRESS_EN
    // Remember that the post-reset preamble has been sent.
    always_ff @(posedge clk_50) begin
        if (!reset_n) pre_done <= 1'b0;
        else if (accept) pre_done <= 1'b1;
    end
`endif

    // Command fields are held for the whole frame.
    always_ff @(posedge clk_50) begin
        if (accept) begin
            wr_l    <= cmd_write;
            phyad_l <= cmd_phyad;
            regad_l <= cmd_regad;
            wdata_l <= cmd_wdata;
        end
    end

    // Read capture: TA error from the second turnaround bit, then 16 data bits.
    always_ff @(posedge clk_50) begin
        if (sample_pt && state == ST_TA && bit_cnt == 6'd0) ta_err <= (phy_mdio != 1'b0);
        if (sample_pt && state == ST_DATA) rx_sr <= {rx_sr[14:0], phy_mdio};
    end

    // Response data is loaded as the frame finishes and held until the next one.
    always_ff @(posedge clk_50) begin
        if (!reset_n) begin
            rsp_rdata <= 16'h0000;
            rsp_err   <= 1'b0;
        end else if (state == ST_END && state_nx == ST_RSP) begin
            rsp_rdata <= wr_l ? 16'h0000 : rx_sr;
            rsp_err   <= !wr_l && ta_err;
        end
    end

endmodule

// File: tb/tb_phy_mdio_ctrl.sv
// tb_phy_mdio_ctrl: randomized bench for phy_mdio_ctrl with a frame-level
// reference model, a simple PHY responder and an MDC-edge bit capture.
module tb_phy_mdio_ctrl;

    localparam int MDC_DIV = 10;

    logic        clk_50 = 1'b0;
    logic        reset_n = 1'b0;
    logic        phy_ready = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [4:0]  cmd_phyad = 5'd0;
    logic [4:0]  cmd_regad = 5'd0;
    logic [15:0] cmd_wdata = 16'd0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        phy_mdc;
    wire         phy_mdio;

    // PHY responder state
    logic        phy_oe = 1'b0;
    logic        phy_out = 1'b0;
    logic        phy_rd = 1'b0;
    logic        phy_present = 1'b0;
    logic [15:0] phy_data = 16'd0;
    int          phy_off = 0;

    // capture / bookkeeping
    logic [63:0] cap_vec = '0;
    int          cap_n = 0;
    int          cyc = 0;
    int          frames = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    pullup (phy_mdio);
    assign phy_mdio = phy_oe ? phy_out : 1'bz;

    phy_mdio_ctrl #(.MDC_DIV(MDC_DIV)) dut (
        .clk_50    (clk_50),
        .reset_n   (reset_n),
        .phy_ready (phy_ready),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_phyad (cmd_phyad),
        .cmd_regad (cmd_regad),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .phy_mdc   (phy_mdc),
        .phy_mdio  (phy_mdio)
    );

    always #10 clk_50 = ~clk_50;

    always @(posedge clk_50) cyc <= cyc + 1;

    // Capture the wire on every MDC rising edge at its frame position.
    always @(posedge phy_mdc) begin
        int p;
        p = cap_n + phy_off;
        if (p < 64) cap_vec[63 - p] = phy_mdio;
        cap_n = cap_n + 1;
    end

    // PHY responder: changes its output when MDC falls, i.e. as bit p begins.
    always @(negedge phy_mdc) begin
        int p;
        p = cap_n + phy_off;
        phy_oe = 1'b0;
        if (phy_rd && phy_present) begin
            if (p == 47) begin
                phy_oe  = 1'b1;
                phy_out = 1'b0;
            end else if (p >= 48 && p <= 63) begin
                phy_oe  = 1'b1;
                phy_out = phy_data[63 - p];
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    // Preamble bits skipped by the frame about to start.
    function automatic int cur_off();
`ifdef MDIO_PRE_SUPPRESS_EN
        return (frames > 0) ? 32 : 0;
`else
        return 0;
`endif
    endfunction

    // Issue one command and check the whole frame against the model.
    // wd is the write data, or the PHY's register content on a read.
    task automatic do_cmd(input logic wr, input logic [4:0] pa, input logic [4:0] ra,
                          input logic [15:0] wd, input logic present,
                          input logic drop_rdy, input int exp_wait);
        int          w, t0, off, n_bits;
        logic [63:0] expv, mask;
        logic [15:0] exp_rd;
        logic        exp_err;

        off    = cur_off();
        n_bits = 65 - off;
        expv   = {32'hFFFF_FFFF, 2'b01, (wr ? 2'b01 : 2'b10), pa, ra, 2'b10, wd};
        mask   = '1;
        if (off != 0) mask[63:32] = '0;
        if (!wr) mask[16:0] = '0;
        exp_rd  = wr ? 16'h0000 : (present ? wd : 16'hFFFF);
        exp_err = !wr && !present;

        cmd_write   = wr;
        cmd_phyad   = pa;
        cmd_regad   = ra;
        cmd_wdata   = wr ? wd : 16'($urandom);
        phy_rd      = !wr;
        phy_present = present;
        phy_data    = wd;
        phy_off     = off;
        cmd_valid   = 1'b1;
        w = 0;
        while (!cmd_ready && w < 100) begin
            @(negedge clk_50);
            w++;
        end
        if (exp_wait >= 0) chk("accept_wait", w, exp_wait);
        if (!cmd_ready) begin
            chk("accept_timeout", cmd_ready, 1'b1);
            cmd_valid = 1'b0;
            return;
        end
        t0      = cyc;
        cap_n   = 0;
        cap_vec = '0;
        frames++;
        @(negedge clk_50);
        cmd_valid = 1'b0;
        chk("ready_low_accept", cmd_ready, 1'b0);
        w = 0;
        while (!rsp_valid && w < 3000) begin
            if (drop_rdy && cap_n >= 20) phy_ready = 1'b0;
            @(negedge clk_50);
            w++;
        end
        chk("rsp_latency", cyc - t0, 1 + n_bits * 2 * MDC_DIV);
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_err", rsp_err, exp_err);
        chk("frame_bits", cap_vec & mask, expv & mask);
        chk("mdc_edges", cap_n, n_bits);
        @(negedge clk_50);
        chk("rsp_one_cycle", rsp_valid, 1'b0);
        chk("rsp_hold", {rsp_err, rsp_rdata}, {exp_err, exp_rd});
        chk("ready_after", cmd_ready, phy_ready);
        chk("mdc_idle", phy_mdc, 1'b0);
    endtask

    initial begin
        int w, viol_rdy, viol_mdc, n_rsp, n_mdc;
        logic wr, pr;

        // reset
        repeat (3) @(negedge clk_50);
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp", {rsp_err, rsp_rdata}, 17'h0);
        chk("rst_mdc", phy_mdc, 1'b0);
        chk("rst_mdio", phy_mdio, 1'b1);
        reset_n = 1'b1;

        // command held while phy_ready is low: nothing happens
        cmd_valid = 1'b1;
        viol_rdy = 0;
        viol_mdc = 0;
        repeat (20) begin
            @(negedge clk_50);
            if (cmd_ready) viol_rdy++;
            if (phy_mdc) viol_mdc++;
        end
        chk("gated_ready", viol_rdy, 0);
        chk("gated_mdc", viol_mdc, 0);
        phy_ready = 1'b1;

        // directed write, accepted one cycle after phy_ready rises
        do_cmd(1'b1, 5'd1, 5'h00, 16'h1140, 1'b0, 1'b0, 1);
        // directed read with a PHY present
        do_cmd(1'b0, 5'd1, 5'h02, 16'h0022, 1'b1, 1'b0, -1);
        // absent PHY, and phy_ready falls mid-frame
        do_cmd(1'b0, 5'd3, 5'h01, 16'h0000, 1'b0, 1'b1, -1);
        repeat (5) @(negedge clk_50);
        chk("ready_stays_low", cmd_ready, 1'b0);
        phy_ready = 1'b1;

        // randomized commands
        for (int i = 0; i < 6; i++) begin
            wr = 1'($urandom_range(0, 1));
            pr = ($urandom_range(0, 3) != 0);
            do_cmd(wr, 5'($urandom), 5'($urandom), 16'($urandom), pr, 1'b0, -1);
        end

        // reset in the middle of a write, while header bit 40 (phyad[0] = 0) is driven
        phy_off   = cur_off();
        phy_rd    = 1'b0;
        cmd_write = 1'b1;
        cmd_phyad = 5'd0;
        cmd_regad = 5'h1F;
        cmd_wdata = 16'hFFFF;
        cmd_valid = 1'b1;
        w = 0;
        while (!cmd_ready && w < 100) begin
            @(negedge clk_50);
            w++;
        end
        chk("abort_accept", cmd_ready, 1'b1);
        cap_n = 0;
        @(negedge clk_50);
        cmd_valid = 1'b0;
        w = 0;
        while (cap_n + phy_off < 40 && w < 2000) begin
            @(negedge clk_50);
            w++;
        end
        repeat (MDC_DIV + 1) @(negedge clk_50);
        chk("abort_bit40", phy_mdio, 1'b0);
        reset_n = 1'b0;
        @(negedge clk_50);
        reset_n = 1'b1;
        frames  = 0;
        chk("abort_mdc", phy_mdc, 1'b0);
        chk("abort_mdio", phy_mdio, 1'b1);
        chk("abort_rsp", rsp_valid, 1'b0);
        chk("abort_ready", cmd_ready, 1'b0);
        n_rsp = 0;
        n_mdc = 0;
        repeat (1400) begin
            @(negedge clk_50);
            if (rsp_valid) n_rsp++;
            if (phy_mdc) n_mdc++;
        end
        chk("abort_no_rsp", n_rsp, 0);
        chk("abort_no_mdc", n_mdc, 0);

        // new commands after the aborted frame
        do_cmd(1'b0, 5'd1, 5'h02, 16'h8001, 1'b1, 1'b0, 0);
        do_cmd(1'b0, 5'd7, 5'h10, 16'h5AA5, 1'b1, 1'b0, 0);
        do_cmd(1'b1, 5'd2, 5'h04, 16'h01E1, 1'b0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
